alarm_scheduler: RTL and testbench

Shares the free-running one-second tick among NCH independent requesters, each arming a countdown alarm of a programmable number of ticks. Expired alarms are reported one at a time over a single valid/ready expiry port, arbitrated round-robin. The block sits between the tick generator and the application FSMs that need second-resolution delays, so one tick counter serves the whole design.

---
 rtl/alarm_sched_pkg.sv | 18 +
 rtl/alarm_channel.sv | 68 ++++++
 rtl/alarm_scheduler.sv | 89 ++++++++
 tb/tb_alarm_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_sched_pkg.sv
// Shared types and constants for the alarm scheduler: channel state encoding,
// default sizing and the width of the expiry channel index.
package alarm_sched_pkg;

  localparam int unsigned DefNch  = 4;
  localparam int unsigned DefCntW = 8;

  typedef logic [1:0] ch_state_t;

  localparam ch_state_t StIdle    = 2'd0;
  localparam ch_state_t StArmed   = 2'd1;
  localparam ch_state_t StPending = 2'd2;

  function automatic int unsigned id_width(int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: arm handshake, tick countdown, cancel, and a pending flag that
// is held until the top-level arbiter reports the expiry.
module alarm_channel
  import alarm_sched_pkg::*;
#(
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             req,
  input  logic [CNT_W-1:0] dur,
  input  logic             cancel,
  input  logic             expire,
  output logic             ack,
  output logic             busy,
  output logic             pending
);

  ch_state_t        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ack_q, ack_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ack_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) begin
          ack_d   = 1'b1;
          count_d = dur;
          state_d = (dur == '0) ? StPending : StArmed;
        end
      end
      StArmed: begin
        // Cancel wins over a coincident tick.
        if (cancel) begin
          state_d = StIdle;
        end else if (tick) begin
          if (count_q == CNT_W'(1)) state_d = StPending;
          else                      count_d = count_q - CNT_W'(1);
        end
      end
      StPending: begin
        if (expire) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ack_q   <= ack_d;
    end
  end

  assign ack     = ack_q;
  assign busy    = (state_q != StIdle);
  assign pending = (state_q == StPending);

endmodule

// File: rtl/alarm_scheduler.sv
// Shares the one-second tick among NCH countdown alarms and reports expiries one at a
// time over a valid/ready port, arbitrated round-robin.
module alarm_scheduler
  import alarm_sched_pkg::*;
#(
  parameter  int unsigned NCH   = DefNch,
  parameter  int unsigned CNT_W = DefCntW,
  localparam int unsigned IdW   = id_width(NCH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [NCH-1:0]     req,
  input  logic [NCH*CNT_W-1:0] dur,
  input  logic [NCH-1:0]     cancel,
  output logic [NCH-1:0]     ack,
  output logic [NCH-1:0]     busy,
  output logic               exp_valid,
  output logic [IdW-1:0]     exp_id,
  input  logic               exp_ready
);

  logic [NCH-1:0] pending;
  logic [NCH-1:0] expire;
  logic           exp_valid_q, exp_valid_d;
  logic [IdW-1:0] exp_id_q, exp_id_d;
  logic [IdW-1:0] ptr_q, ptr_d;
  logic [IdW-1:0] cand;
  int unsigned    idx;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    alarm_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .req     (req[i]),
      .dur     (dur[i*CNT_W +: CNT_W]),
      .cancel  (cancel[i]),
      .expire  (expire[i]),
      .ack     (ack[i]),
      .busy    (busy[i]),
      .pending (pending[i])
    );
  end

  always_comb begin
    exp_valid_d = exp_valid_q;
    exp_id_d    = exp_id_q;
    ptr_d       = ptr_q;
    expire      = '0;
    idx         = 0;
    cand        = '0;
    if (exp_valid_q) begin
      if (exp_ready) begin
        expire[exp_id_q] = 1'b1;
        exp_valid_d      = 1'b0;
        ptr_d            = (exp_id_q == IdW'(NCH - 1)) ? '0 : exp_id_q + IdW'(1);
      end
    end else begin
      // First pending channel at or after ptr, wrapping.
      for (int unsigned k = 0; k < NCH; k++) begin
        idx  = (32'(ptr_q) + k) % NCH;
        cand = IdW'(idx);
        if (!exp_valid_d && pending[cand]) begin
          exp_valid_d = 1'b1;
          exp_id_d    = cand;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_valid_q <= 1'b0;
      exp_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      exp_valid_q <= exp_valid_d;
      exp_id_q    <= exp_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign exp_valid = exp_valid_q;
  assign exp_id    = exp_id_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Vector table plus hand-written corner sequences for alarm_scheduler; expiry ids are
// predicted into a scoreboard queue and checked as each report handshakes.
module tb_alarm_scheduler;

  localparam logic [3:0] NONE = 4'hf;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] dur = '0;
  logic [3:0]  cancel = '0;
  logic [3:0]  ack;
  logic [3:0]  busy;
  logic        exp_valid;
  logic [1:0]  exp_id;
  logic        exp_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [1:0] sb[$];

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] dur;
    logic [3:0]  cancel;
    logic        tick;
    logic        ready;
    logic [3:0]  push0;
    logic [3:0]  push1;
    logic [3:0]  ack;
    logic [3:0]  busy;
    logic        valid;
    logic        chk_id;
    logic [1:0]  id;
  } vec_t;

  vec_t tbl[$];

  alarm_scheduler #(
    .NCH   (4),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .req       (req),
    .dur       (dur),
    .cancel    (cancel),
    .ack       (ack),
    .busy      (busy),
    .exp_valid (exp_valid),
    .exp_id    (exp_id),
    .exp_ready (exp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic rst, logic [3:0] rq, logic [31:0] d, logic [3:0] cn,
                              logic tk, logic rdy, logic [3:0] p0, logic [3:0] p1,
                              logic [3:0] ak, logic [3:0] bs, logic vl, logic ci,
                              logic [1:0] id);
    vec_t v;
    v.rst = rst; v.req = rq; v.dur = d; v.cancel = cn; v.tick = tk; v.ready = rdy;
    v.push0 = p0; v.push1 = p1; v.ack = ak; v.busy = bs; v.valid = vl; v.chk_id = ci;
    v.id = id;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int row);
    req = v.req; dur = v.dur; cancel = v.cancel; tick = v.tick; exp_ready = v.ready;
    if (v.push0 != NONE) sb.push_back(v.push0[1:0]);
    if (v.push1 != NONE) sb.push_back(v.push1[1:0]);
    if (v.rst) reset = 1'b1;
    step();
    reset = 1'b0;
    chk($sformatf("row%0d_ack", row), 32'(ack), 32'(v.ack));
    chk($sformatf("row%0d_busy", row), 32'(busy), 32'(v.busy));
    chk($sformatf("row%0d_valid", row), 32'(exp_valid), 32'(v.valid));
    if (v.chk_id) chk($sformatf("row%0d_id", row), 32'(exp_id), 32'(v.id));
  endtask

  task automatic do_reset();
    req = '0; cancel = '0; tick = 1'b0; dur = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Report monitor: scoreboard pop on handshake, id stability while stalled.
  logic       stalled = 1'b0;
  logic [1:0] stall_id = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_valid", 32'(exp_valid), 32'd1);
          chk("stall_id", 32'(exp_id), 32'(stall_id));
        end
        if (exp_valid && exp_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_report", 32'(exp_id), 32'hdead);
          end else begin
            chk("report_id", 32'(exp_id), 32'(sb.pop_front()));
          end
        end
        stalled  = exp_valid && !exp_ready;
        stall_id = exp_id;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // Single alarm dur=3.
    tbl.push_back(mk(1, 4'b0000, 32'h0, 4'b0, 0, 1, NONE, NONE, 4'b0000, 4'b0000, 0, 1, 2'd0));
    tbl.push_back(mk(0, 4'b0001, 32'h3, 4'b0, 0, 1, NONE, NONE, 4'b0001, 4'b0001, 0, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 32'h0, 4'b0, 1, 1, NONE, NONE, 4'b0000, 4'b0001, 0, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 32'h0, 4'b0, 1, 1, NONE, NONE, 4'b0000, 4'b0001, 0, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 32'h0, 4'b0, 1, 1, 4'd0, NONE, 4'b0000, 4'b0001, 0, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 32'h0, 4'b0, 0, 1, NONE, NONE, 4'b0000, 4'b0001, 1, 1, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 32'h0, 4'b0, 0, 1, NONE, NONE, 4'b0000, 4'b0000, 0, 0, 2'd0));
    // Simultaneous expiry of ch1 and ch2, ptr=0.
    tbl.push_back(mk(1, 4'b0000, 32'h0, 4'b0, 0, 1, NONE, NONE, 4'b0000, 4'b0000, 0, 1, 2'd0));
    tbl.push_back(mk(0, 4'b0110, 32'h00020200, 4'b0, 0, 1, NONE, NONE, 4'b0110, 4'b0110, 0, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 32'h0, 4'b0, 1, 1, NONE, NONE, 4'b0000, 4'b0110, 0, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 32'h0, 4'b0, 1, 1, 4'd1, 4'd2, 4'b0000, 4'b0110, 0, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 32'h0, 4'b0, 0, 1, NONE, NONE, 4'b0000, 4'b0110, 1, 1, 2'd1));
    tbl.push_back(mk(0, 4'b0000, 32'h0, 4'b0, 0, 1, NONE, NONE, 4'b0000, 4'b0100, 0, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 32'h0, 4'b0, 0, 1, NONE, NONE, 4'b0000, 4'b0100, 1, 1, 2'd2));
    tbl.push_back(mk(0, 4'b0000, 32'h0, 4'b0, 0, 1, NONE, NONE, 4'b0000, 4'b0000, 0, 0, 2'd0));
    // Cancel ch3 after two ticks, coincident with a third tick.
    tbl.push_back(mk(1, 4'b0000, 32'h0, 4'b0, 0, 1, NONE, NONE, 4'b0000, 4'b0000, 0, 1, 2'd0));
    tbl.push_back(mk(0, 4'b1000, 32'h05000000, 4'b0, 0, 1, NONE, NONE, 4'b1000, 4'b1000, 0, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 32'h0, 4'b0, 1, 1, NONE, NONE, 4'b0000, 4'b1000, 0, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 32'h0, 4'b0, 1, 1, NONE, NONE, 4'b0000, 4'b1000, 0, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 32'h0, 4'b1000, 1, 1, NONE, NONE, 4'b0000, 4'b0000, 0, 0, 2'd0));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(0, 4'b0000, 32'h0, 4'b0, 1, 1, NONE, NONE, 4'b0000, 4'b0000, 0, 0, 2'd0));
    // dur=0 goes straight to pending.
    tbl.push_back(mk(1, 4'b0000, 32'h0, 4'b0, 0, 1, NONE, NONE, 4'b0000, 4'b0000, 0, 1, 2'd0));
    tbl.push_back(mk(0, 4'b0001, 32'h0, 4'b0, 0, 1, 4'd0, NONE, 4'b0001, 4'b0001, 0, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 32'h0, 4'b0, 0, 1, NONE, NONE, 4'b0000, 4'b0001, 1, 1, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 32'h0, 4'b0, 0, 1, NONE, NONE, 4'b0000, 4'b0000, 0, 0, 2'd0));

    step();
    foreach (tbl[i]) apply(tbl[i], i);

    // Stalled consumer with ch0 and ch1 pending; req to a pending channel is ignored.
    exp_ready = 1'b0;
    do_reset();
    req = 4'b0011; dur = 32'h00000101;
    step();
    chk("stall_arm_ack", 32'(ack), 32'h3);
    req = '0; tick = 1'b1;
    step();
    tick = 1'b0;
    sb.push_back(2'd0);
    sb.push_back(2'd1);
    chk("stall_pend_busy", 32'(busy), 32'h3);
    chk("stall_pend_valid", 32'(exp_valid), 32'd0);
    step();
    chk("stall_first_valid", 32'(exp_valid), 32'd1);
    chk("stall_first_id", 32'(exp_id), 32'd0);
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_hold_id", 32'(exp_id), 32'd0);
      chk("stall_no_ack", 32'(ack), 32'd0);
    end
    req = '0;
    exp_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    chk("stall_drain_left", 32'(sb.size()), 32'd0);
    chk("stall_drain_busy", 32'(busy), 32'd0);
    chk("stall_drain_valid", 32'(exp_valid), 32'd0);

    // Reset while ch2 armed and ch1 pending; both alarms are lost.
    exp_ready = 1'b0;
    do_reset();
    req = 4'b0110; dur = 32'h00040000;
    step();
    req = '0;
    chk("rst_arm_busy", 32'(busy), 32'h6);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("rst_pre_valid", 32'(exp_valid), 32'd1);
    chk("rst_pre_id", 32'(exp_id), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_ack", 32'(ack), 32'd0);
    chk("rst_async_valid", 32'(exp_valid), 32'd0);
    chk("rst_async_id", 32'(exp_id), 32'd0);
    step();
    reset = 1'b0;
    exp_ready = 1'b1;
    tick = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rst_after_busy", 32'(busy), 32'd0);
      chk("rst_after_valid", 32'(exp_valid), 32'd0);
    end
    tick = 1'b0;
    step();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
